// File: rtl/raizing_vcount_irq.sv
// ---------------------------------------------------------------------------
// raizing_vcount_irq
//
// Raster-status and interrupt stage that sits behind the video timing
// generator. It samples the pixel counters and blanking flags on pixel-clock
// ticks and produces:
//   * the GCU vertical-count status word read by the 68k,
//   * a VBLANK interrupt (set on the falling edge of lvbl),
//   * a programmable raster-line interrupt (set at irq_line / hs_start),
//   * a free-running frame counter that advances once per VBLANK edge.
// Each interrupt has an acknowledge input. A rising edge on the acknowledge
// clears the request. Acknowledges are watched on every clk96 cycle, not just
// on ticks.
//
// Parameters
//   RASTER_EN  1 enables the raster-line interrupt. 0 ties it off.
//   FRAME_W    width of frame_cnt.
//
// Ports
//   clk96        in   system clock. All state changes on its rising edge.
//   reset96      in   asynchronous, active-low reset.
//   pxl_cen      in   pixel clock enable. A clk96 edge with pxl_cen=1 is a tick.
//   hpos, vpos   in   9-bit horizontal / vertical pixel counters.
//   lhbl, lvbl   in   active-low horizontal / vertical blank.
//   hs_start/end in   hsync window bounds. The window is [start, end).
//   vs_start/end in   vsync window bounds. The window is [start, end).
//   irq_line     in   line number for the raster interrupt.
//   rd_stb       in   CPU status-read strobe. status is frozen while it is high.
//   ack_vbl      in   VBLANK acknowledge. The rising edge is the active event.
//   ack_raster   in   raster acknowledge. The rising edge is the active event.
//   status       out  {hwin, vwin, vblk, 4'b0, vline}, registered.
//   irq_vbl      out  VBLANK interrupt request.
//   irq_raster   out  raster-line interrupt request.
//   frame_cnt    out  count of VBLANK edges, modulo 2**FRAME_W.
//
// Every output comes straight from a flip-flop. There is no combinational
// path from any input to any output.
// ---------------------------------------------------------------------------
module raizing_vcount_irq #(
    parameter int RASTER_EN = 1,
    parameter int FRAME_W   = 8
) (
    input  logic               clk96,
    input  logic               reset96,
    input  logic               pxl_cen,
    input  logic [8:0]         hpos,
    input  logic [8:0]         vpos,
    input  logic               lhbl,
    input  logic               lvbl,
    input  logic [8:0]         hs_start,
    input  logic [8:0]         hs_end,
    input  logic [8:0]         vs_start,
    input  logic [8:0]         vs_end,
    input  logic [8:0]         irq_line,
    input  logic               rd_stb,
    input  logic               ack_vbl,
    input  logic               ack_raster,
    output logic [15:0]        status,
    output logic               irq_vbl,
    output logic               irq_raster,
    output logic [FRAME_W-1:0] frame_cnt
);

    // The last line the timing generator ever produces. Raster lines beyond it
    // are rejected explicitly. This keeps the interrupt quiet even if vpos is
    // ever driven past the end of the frame.
    localparam logic [8:0]         LAST_LINE  = 9'd262;
    localparam int                 IRQ_VBL    = 0;
    localparam int                 IRQ_RASTER = 1;
    localparam int                 N_IRQ      = 2;
    localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);

    // -----------------------------------------------------------------------
    // Raster sampling (tick domain)
    // -----------------------------------------------------------------------
    logic       tick;
    logic       hs_hit;
    logic       hwin_next;
    logic       vwin_next;
    logic       vblk_next;
    logic [8:0] vline_next;
    logic       hwin_reg;
    logic       vwin_reg;
    logic       vblk_reg;
    logic [8:0] vline_reg;

    assign tick = pxl_cen;

    // The windows are half-open, [start, end). If start >= end, no hpos/vpos
    // value can satisfy both compares, so the window never opens. No separate
    // check is needed for that case.
    always_comb begin
        hs_hit     = (hpos == hs_start);
        hwin_next  = (hpos >= hs_start) && (hpos < hs_end);
        vwin_next  = (vpos >= vs_start) && (vpos < vs_end);
        vblk_next  = ~lvbl;
        // The line number is taken at the hsync boundary rather than at
        // hpos 0. This matches the line the GCU considers current.
        vline_next = hs_hit ? vpos : vline_reg;
    end

    always_ff @(posedge clk96 or negedge reset96) begin
        if (!reset96) begin
            hwin_reg  <= 1'b0;
            vwin_reg  <= 1'b0;
            vblk_reg  <= 1'b0;
            vline_reg <= 9'd0;
        end else if (tick) begin
            hwin_reg  <= hwin_next;
            vwin_reg  <= vwin_next;
            vblk_reg  <= vblk_next;
            vline_reg <= vline_next;
        end
    end

    // -----------------------------------------------------------------------
    // Status word with read freeze
    // -----------------------------------------------------------------------
    // status loads the live word only on ticks where no read is in progress.
    // Holding it for the whole rd_stb bus cycle means the 68k never sees a
    // word whose fields come from two different samples.
    logic [15:0] live_word;
    logic [15:0] status_reg;

    assign live_word = {hwin_reg, vwin_reg, vblk_reg, 4'b0000, vline_reg};

    always_ff @(posedge clk96 or negedge reset96) begin
        if (!reset96) begin
            status_reg <= 16'd0;
        end else if (tick && !rd_stb) begin
            status_reg <= live_word;
        end
    end

    // -----------------------------------------------------------------------
    // Interrupt sources
    // -----------------------------------------------------------------------
    // lvbl_d resets to 1, the "not blanking" level. So the first tick after
    // reset only reports an edge if lvbl is really low at that tick.
    logic lvbl_d_reg;
    logic vbl_edge;
    logic line_ok;
    logic raster_hit;

    assign vbl_edge   = tick && lvbl_d_reg && !lvbl;
    assign line_ok    = (irq_line <= LAST_LINE);
    assign raster_hit = tick && hs_hit && (vpos == irq_line) && line_ok;

    always_ff @(posedge clk96 or negedge reset96) begin
        if (!reset96) begin
            lvbl_d_reg <= 1'b1;
        end else if (tick) begin
            lvbl_d_reg <= lvbl;
        end
    end

    // -----------------------------------------------------------------------
    // Pending/acknowledge channels, one per source
    // -----------------------------------------------------------------------
    logic [N_IRQ-1:0] irq_set;
    logic [N_IRQ-1:0] irq_ack;
    logic [N_IRQ-1:0] irq_pend;

    always_comb begin
        irq_set             = '0;
        irq_ack             = '0;
        irq_set[IRQ_VBL]    = vbl_edge;
        irq_set[IRQ_RASTER] = raster_hit;
        irq_ack[IRQ_VBL]    = ack_vbl;
        irq_ack[IRQ_RASTER] = ack_raster;
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_IRQ; gi = gi + 1) begin : g_irq
            if (gi == IRQ_RASTER && RASTER_EN == 0) begin : g_off
                // The raster source is compiled out. Its request stays low
                // and its set/ack inputs are deliberately ignored.
                logic unused_src;
                assign unused_src   = irq_set[gi] ^ irq_ack[gi];
                assign irq_pend[gi] = 1'b0;
            end else begin : g_on
                logic ack_d_reg;
                logic pend_reg;
                logic ack_rise;
                logic pend_next;

                // Only the rising edge of the acknowledge clears the request.
                // An ack that is held high therefore cannot mask a later set.
                // A set in the same cycle as a clear wins, so an event that
                // arrives while the CPU is acknowledging is not lost. Setting
                // while already pending changes nothing; only one request per
                // source is outstanding.
                always_comb begin
                    ack_rise  = irq_ack[gi] && !ack_d_reg;
                    pend_next = pend_reg;
                    if (irq_set[gi]) begin
                        pend_next = 1'b1;
                    end else if (ack_rise) begin
                        pend_next = 1'b0;
                    end
                end

                // The acknowledge edge detector runs on every clk96 cycle, not
                // only on ticks. The CPU side is not tied to the pixel clock.
                always_ff @(posedge clk96 or negedge reset96) begin
                    if (!reset96) begin
                        ack_d_reg <= 1'b0;
                        pend_reg  <= 1'b0;
                    end else begin
                        ack_d_reg <= irq_ack[gi];
                        pend_reg  <= pend_next;
                    end
                end

                assign irq_pend[gi] = pend_reg;
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Frame counter
    // -----------------------------------------------------------------------
    // The counter advances on every VBLANK edge, whether or not the previous
    // VBLANK request has been acknowledged. It wraps naturally from all-ones
    // to 0.
    logic [FRAME_W-1:0] frame_reg;

    always_ff @(posedge clk96 or negedge reset96) begin
        if (!reset96) begin
            frame_reg <= '0;
        end else if (vbl_edge) begin
            frame_reg <= frame_reg + FRAME_ONE;
        end
    end

    // lhbl is part of the timing bundle but carries no information this stage
    // needs.
    logic unused_inputs;
    assign unused_inputs = lhbl;

    assign status     = status_reg;
    assign irq_vbl    = irq_pend[IRQ_VBL];
    assign irq_raster = irq_pend[IRQ_RASTER];
    assign frame_cnt  = frame_reg;

endmodule

// File: tb/tb_raizing_vcount_irq.sv
// ---------------------------------------------------------------------------
// Self-checking bench for raizing_vcount_irq.
//
// Two instances are driven from the same stimulus: one with the raster
// interrupt enabled and one with it compiled out. Every clk96 cycle is checked
// against a behavioural model. In the model, the status word is the word
// computed from the previous tick's sample, and the frame counter is a plain
// integer count of VBLANK edges.
//
// The bench runs these phases:
//   * a directed vector table with hand-derived expected values,
//   * hand-written multi-cycle scenarios,
//   * a randomized phase that is checked only against the model.
// ---------------------------------------------------------------------------
module tb_raizing_vcount_irq;

    logic clk96 = 1'b0;
    always #5 clk96 = ~clk96;

    logic       reset96;
    logic       pxl_cen;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic       lhbl;
    logic       lvbl;
    logic [8:0] hs_start;
    logic [8:0] hs_end;
    logic [8:0] vs_start;
    logic [8:0] vs_end;
    logic [8:0] irq_line;
    logic       rd_stb;
    logic       ack_vbl;
    logic       ack_raster;

    logic [15:0] status;
    logic        irq_vbl;
    logic        irq_raster;
    logic [7:0]  frame_cnt;

    logic [15:0] status_off;
    logic        irq_vbl_off;
    logic        irq_raster_off;
    logic [7:0]  frame_cnt_off;

    raizing_vcount_irq #(.RASTER_EN(1), .FRAME_W(8)) dut (
        .clk96(clk96), .reset96(reset96), .pxl_cen(pxl_cen),
        .hpos(hpos), .vpos(vpos), .lhbl(lhbl), .lvbl(lvbl),
        .hs_start(hs_start), .hs_end(hs_end),
        .vs_start(vs_start), .vs_end(vs_end),
        .irq_line(irq_line), .rd_stb(rd_stb),
        .ack_vbl(ack_vbl), .ack_raster(ack_raster),
        .status(status), .irq_vbl(irq_vbl), .irq_raster(irq_raster),
        .frame_cnt(frame_cnt)
    );

    raizing_vcount_irq #(.RASTER_EN(0), .FRAME_W(8)) dut_off (
        .clk96(clk96), .reset96(reset96), .pxl_cen(pxl_cen),
        .hpos(hpos), .vpos(vpos), .lhbl(lhbl), .lvbl(lvbl),
        .hs_start(hs_start), .hs_end(hs_end),
        .vs_start(vs_start), .vs_end(vs_end),
        .irq_line(irq_line), .rd_stb(rd_stb),
        .ack_vbl(ack_vbl), .ack_raster(ack_raster),
        .status(status_off), .irq_vbl(irq_vbl_off), .irq_raster(irq_raster_off),
        .frame_cnt(frame_cnt_off)
    );

    int n_cmp;
    int n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------
    logic [15:0] m_status;
    logic [15:0] m_last_word;   // word derived from the most recent tick sample
    logic [8:0]  m_line;        // line seen at the most recent hsync-start tick
    logic        m_lvbl_seen;   // lvbl at the most recent tick (1 after reset)
    logic        m_ackv_seen;
    logic        m_ackr_seen;
    logic        m_pend_vbl;
    logic        m_pend_ras;
    int          m_frames;

    function automatic logic inside_win(input logic [8:0] p, input logic [8:0] s, input logic [8:0] e);
        return (p >= s) && (p < e);
    endfunction

    task automatic model_reset();
        m_status    = 16'd0;
        m_last_word = 16'd0;
        m_line      = 9'd0;
        m_lvbl_seen = 1'b1;
        m_ackv_seen = 1'b0;
        m_ackr_seen = 1'b0;
        m_pend_vbl  = 1'b0;
        m_pend_ras  = 1'b0;
        m_frames    = 0;
    endtask

    task automatic model_step();
        logic set_v, set_r, clr_v, clr_r;
        set_v = 1'b0;
        set_r = 1'b0;
        if (pxl_cen) begin
            // status shows the word sampled one tick earlier, unless a read
            // is in progress.
            if (!rd_stb) m_status = m_last_word;
            if (hpos == hs_start) m_line = vpos;
            m_last_word = {inside_win(hpos, hs_start, hs_end),
                           inside_win(vpos, vs_start, vs_end),
                           ~lvbl, 4'b0000, m_line};
            set_v = m_lvbl_seen && !lvbl;
            m_lvbl_seen = lvbl;
            set_r = (hpos == hs_start) && (vpos == irq_line) && (irq_line <= 9'd262);
        end
        clr_v = ack_vbl && !m_ackv_seen;
        clr_r = ack_raster && !m_ackr_seen;
        m_ackv_seen = ack_vbl;
        m_ackr_seen = ack_raster;
        if (set_v) begin
            m_pend_vbl = 1'b1;
            m_frames++;
        end else if (clr_v) begin
            m_pend_vbl = 1'b0;
        end
        if (set_r) m_pend_ras = 1'b1;
        else if (clr_r) m_pend_ras = 1'b0;
    endtask

    task automatic compare_all();
        check("status",         status,         m_status);
        check("irq_vbl",        irq_vbl,        m_pend_vbl);
        check("irq_raster",     irq_raster,     m_pend_ras);
        check("frame_cnt",      frame_cnt,      m_frames % 256);
        check("off_status",     status_off,     m_status);
        check("off_irq_vbl",    irq_vbl_off,    m_pend_vbl);
        check("off_irq_raster", irq_raster_off, 32'd0);
        check("off_frame_cnt",  frame_cnt_off,  m_frames % 256);
    endtask

    // One clk96 cycle. The model consumes the inputs held across the edge,
    // and the outputs are sampled 1 time unit after the edge.
    task automatic cycle();
        model_step();
        @(posedge clk96);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic tick_at(input int h, input int v, input logic l);
        hpos    = h[8:0];
        vpos    = v[8:0];
        lvbl    = l;
        pxl_cen = 1'b1;
        cycle();
        pxl_cen = 1'b0;
    endtask

    // Asserts reset between clock edges. The outputs must clear without
    // waiting for an edge.
    task automatic do_reset();
        reset96 = 1'b0;
        #2;
        check("rst_status",     status,        32'd0);
        check("rst_irq_vbl",    irq_vbl,       32'd0);
        check("rst_irq_raster", irq_raster,    32'd0);
        check("rst_frame_cnt",  frame_cnt,     32'd0);
        check("rst_off_status", status_off,    32'd0);
        check("rst_off_frame",  frame_cnt_off, 32'd0);
        model_reset();
        @(posedge clk96);
        @(posedge clk96);
        #1;
        reset96 = 1'b1;
        $display("reset applied at %0t", $time);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        cen;
        logic [8:0]  h;
        logic [8:0]  v;
        logic        lv;
        logic        rd;
        logic        akv;
        logic        akr;
        logic [8:0]  line;
        logic [15:0] e_status;
        logic        e_iv;
        logic        e_ir;
        logic [7:0]  e_frame;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    function automatic vec_t mk(input int cen, input int h, input int v, input int lv,
                                input int rd, input int akv, input int akr, input int line,
                                input int st, input int iv, input int ir, input int fr);
        vec_t r;
        r.cen      = cen[0];
        r.h        = h[8:0];
        r.v        = v[8:0];
        r.lv       = lv[0];
        r.rd       = rd[0];
        r.akv      = akv[0];
        r.akr      = akr[0];
        r.line     = line[8:0];
        r.e_status = st[15:0];
        r.e_iv     = iv[0];
        r.e_ir     = ir[0];
        r.e_frame  = fr[7:0];
        return r;
    endfunction

    int   first_h;
    int   win_ticks;
    int   ras_rises;
    int   ras_h;
    int   ras_v;
    int   rise_h;
    int   rise_v;
    int   hits;
    logic prev_irq;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        reset96    = 1'b1;
        pxl_cen    = 1'b0;
        hpos       = 9'd0;
        vpos       = 9'd0;
        lhbl       = 1'b1;
        lvbl       = 1'b1;
        hs_start   = 9'd325;
        hs_end     = 9'd380;
        vs_start   = 9'd232;
        vs_end     = 9'd245;
        irq_line   = 9'd100;
        rd_stb     = 1'b0;
        ack_vbl    = 1'b0;
        ack_raster = 1'b0;
        model_reset();
        #1;
        do_reset();

        // Columns: cen, h, v, lvbl, rd, ack_vbl, ack_raster, irq_line,
        //          then expected status, irq_vbl, irq_raster, frame.
        vecs[0]  = mk(1, 325, 100, 1, 0, 0, 0, 100, 16'h0000, 0, 1, 0); // raster hit
        vecs[1]  = mk(1, 326, 100, 1, 0, 0, 0, 100, 16'h8064, 0, 1, 0); // hwin + line 100
        vecs[2]  = mk(0, 326, 100, 1, 0, 0, 1, 100, 16'h8064, 0, 0, 0); // raster ack
        vecs[3]  = mk(1, 380, 240, 0, 0, 0, 1, 100, 16'h8064, 1, 0, 1); // VBLANK edge
        vecs[4]  = mk(1, 381, 240, 0, 0, 0, 1, 100, 16'h6064, 1, 0, 1); // hwin end, vwin+vblk
        vecs[5]  = mk(0, 381, 240, 0, 0, 1, 0, 100, 16'h6064, 0, 0, 1); // vbl ack
        vecs[6]  = mk(1, 325, 241, 0, 1, 1, 0, 100, 16'h6064, 0, 0, 1); // read freeze
        vecs[7]  = mk(1, 326, 241, 0, 1, 1, 0, 100, 16'h6064, 0, 0, 1);
        vecs[8]  = mk(0, 326, 241, 0, 0, 1, 0, 100, 16'h6064, 0, 0, 1); // rd falls, no tick
        vecs[9]  = mk(1, 327, 241, 0, 0, 1, 0, 100, 16'hE0F1, 0, 0, 1); // reload
        vecs[10] = mk(1, 328,   0, 1, 0, 0, 0, 100, 16'hE0F1, 0, 0, 1);
        vecs[11] = mk(1, 329,   0, 0, 0, 1, 0, 100, 16'h80F1, 1, 0, 2); // set + ack rise: set wins
        vecs[12] = mk(0, 329,   0, 0, 0, 1, 0, 100, 16'h80F1, 1, 0, 2); // held ack: no clear
        vecs[13] = mk(1, 325, 262, 0, 0, 0, 0, 262, 16'hA0F1, 1, 1, 2); // last legal line fires
        vecs[14] = mk(1, 326, 262, 0, 0, 0, 0, 262, 16'hA106, 1, 1, 2);

        for (int i = 0; i < NV; i++) begin
            pxl_cen    = vecs[i].cen;
            hpos       = vecs[i].h;
            vpos       = vecs[i].v;
            lvbl       = vecs[i].lv;
            rd_stb     = vecs[i].rd;
            ack_vbl    = vecs[i].akv;
            ack_raster = vecs[i].akr;
            irq_line   = vecs[i].line;
            cycle();
            check($sformatf("vec%0d_status", i),     status,     vecs[i].e_status);
            check($sformatf("vec%0d_irq_vbl", i),    irq_vbl,    vecs[i].e_iv);
            check($sformatf("vec%0d_irq_raster", i), irq_raster, vecs[i].e_ir);
            check($sformatf("vec%0d_frame", i),      frame_cnt,  vecs[i].e_frame);
            $display("vec %0d: status=%04h irq_vbl=%0b irq_raster=%0b frame=%0d",
                     i, status, irq_vbl, irq_raster, frame_cnt);
        end
        pxl_cen    = 1'b0;
        rd_stb     = 1'b0;
        ack_vbl    = 1'b0;
        ack_raster = 1'b0;
        irq_line   = 9'd100;

        // ---- Line latch and raster interrupt over lines 99 and 100 ----
        do_reset();
        first_h   = -1;
        win_ticks = 0;
        ras_rises = 0;
        ras_h     = -1;
        ras_v     = -1;
        prev_irq  = 1'b0;
        for (int v = 99; v <= 100; v++) begin
            for (int h = 0; h < 432; h++) begin
                tick_at(h, v, 1'b1);
                if (v == 100) begin
                    if (status[8:0] == 9'd100 && first_h < 0) first_h = h;
                    if (status[15]) win_ticks++;
                end
                if (irq_raster && !prev_irq) begin
                    ras_rises++;
                    ras_h = h;
                    ras_v = v;
                end
                prev_irq = irq_raster;
                idle(3);
            end
        end
        check("latch_first_h", first_h, 326);
        check("hwin_ticks",    win_ticks, 55);
        check("raster_rises",  ras_rises, 1);
        check("raster_h",      ras_h, 325);
        check("raster_v",      ras_v, 100);
        $display("line latch: status=100 from hpos %0d, hwin ticks %0d, raster at %0d/%0d",
                 first_h, win_ticks, ras_v, ras_h);

        // ---- VBLANK interrupt at the vpos 240 transition ----
        do_reset();
        rise_h   = -1;
        rise_v   = -1;
        prev_irq = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick_at((k < 4) ? 428 + k : k - 4, (k < 4) ? 239 : 240, (k < 4));
            if (irq_vbl && !prev_irq) begin
                rise_h = (k < 4) ? 428 + k : k - 4;
                rise_v = (k < 4) ? 239 : 240;
                check("vbl_frame_1", frame_cnt, 32'd1);
            end
            prev_irq = irq_vbl;
            idle(3);
        end
        check("vbl_rise_v", rise_v, 240);
        check("vbl_rise_h", rise_h, 0);
        ack_vbl = 1'b1;
        cycle();
        check("vbl_ack_clear", irq_vbl, 32'd0);
        ack_vbl = 1'b0;
        cycle();
        $display("vblank: irq rose at %0d/%0d, frame=%0d", rise_v, rise_h, frame_cnt);

        // ---- Frame counter wrap after 256 VBLANK edges ----
        do_reset();
        for (int f = 0; f < 256; f++) begin
            ack_vbl = 1'($urandom_range(0, 1));
            tick_at(0, 10, 1'b1);
            tick_at(0, 240, 1'b0);
            if (f == 254) check("frame_255", frame_cnt, 32'd255);
        end
        ack_vbl = 1'b0;
        cycle();
        check("frame_wrap", frame_cnt, 32'd0);
        $display("frame wrap: frame=%0d after 256 edges", frame_cnt);

        // ---- irq_line out of range never fires; last line does ----
        do_reset();
        irq_line = 9'd300;
        hits     = 0;
        for (int fr = 0; fr < 2; fr++) begin
            for (int v = 0; v <= 262; v++) begin
                for (int h = 324; h <= 326; h++) begin
                    tick_at(h, v, 1'b1);
                    if (irq_raster) hits++;
                end
            end
        end
        check("line300_hits", hits, 0);
        irq_line = 9'd262;
        tick_at(325, 262, 1'b1);
        check("line262_fires", irq_raster, 32'd1);
        $display("raster range: line 300 hits %0d, line 262 irq=%0b", hits, irq_raster);
        irq_line = 9'd100;

        // ---- Read freeze across the hsync boundary ----
        do_reset();
        tick_at(324, 49, 1'b1);
        tick_at(325, 49, 1'b1);
        tick_at(326, 49, 1'b1);
        check("freeze_pre", status, 32'h8031);
        rd_stb = 1'b1;
        for (int h = 323; h <= 326; h++) begin
            tick_at(h, 50, 1'b1);
            check("freeze_hold", status, 32'h8031);
            cycle();
            check("freeze_hold_idle", status, 32'h8031);
        end
        rd_stb = 1'b0;
        cycle();
        check("freeze_fall_no_tick", status, 32'h8031);
        tick_at(327, 50, 1'b1);
        check("freeze_reload", status, 32'h8032);
        $display("read freeze: status after release=%04h", status);

        // ---- Reset mid-frame with a pending VBLANK request ----
        do_reset();
        tick_at(0, 239, 1'b1);
        tick_at(0, 240, 1'b0);
        tick_at(0, 149, 1'b1);
        tick_at(100, 150, 1'b1);
        check("midrst_pending", irq_vbl, 32'd1);
        do_reset();
        hits = 0;
        for (int h = 101; h <= 140; h++) begin
            tick_at(h, 150, 1'b1);
            if (irq_vbl) hits++;
        end
        check("midrst_no_spurious", hits, 0);
        tick_at(0, 240, 1'b0);
        check("midrst_true_edge", irq_vbl, 32'd1);
        $display("mid-frame reset: spurious=%0d, irq after true edge=%0b", hits, irq_vbl);

        // ---- Randomized phase, checked against the model ----
        for (int r = 0; r < 20; r++) begin
            hs_start = 9'($urandom_range(0, 15));
            hs_end   = 9'($urandom_range(0, 15));
            vs_start = 9'($urandom_range(0, 15));
            vs_end   = 9'($urandom_range(0, 15));
            for (int c = 0; c < 250; c++) begin
                if ($urandom_range(0, 499) == 0) do_reset();
                pxl_cen    = 1'($urandom_range(0, 1));
                hpos       = 9'($urandom_range(0, 15));
                vpos       = ($urandom_range(0, 9) == 0) ? 9'd300 : 9'($urandom_range(0, 15));
                lvbl       = ($urandom_range(0, 3) != 0);
                rd_stb     = ($urandom_range(0, 3) == 0);
                ack_vbl    = 1'($urandom_range(0, 1));
                ack_raster = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 15) == 0)
                    irq_line = ($urandom_range(0, 3) == 0) ? 9'd300 : 9'($urandom_range(0, 15));
                cycle();
            end
            $display("random round %0d: bounds h[%0d,%0d) v[%0d,%0d) frame=%0d",
                     r, hs_start, hs_end, vs_start, vs_end, frame_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/raizing_vcount_irq.md
# raizing_vcount_irq

Raster-status and interrupt stage fed by the video timing generator. It consumes the pixel counters, blanking flags and sync-window bounds. It produces three things: the GCU vertical-count status word that the 68k reads, a VBLANK interrupt, and a programmable raster-line interrupt, each with an acknowledge handshake. It also keeps a free-running frame counter for the sound/CPU glue.

## Interface
Parameters:
- RASTER_EN, 1: 1 enables the raster-line interrupt. 0 ties irq_raster and its pending bit to 0.
- FRAME_W, 8: width of frame_cnt.

Ports:
- clk96  in  1  system clock; all state on rising edge.
- reset96  in  1  asynchronous, active-low reset.
- pxl_cen  in  1  pixel clock enable; raster inputs are sampled only when high.
- hpos  in  9  horizontal pixel counter, 0..431.
- vpos  in  9  vertical line counter, 0..262.
- lhbl  in  1  active-low horizontal blank.
- lvbl  in  1  active-low vertical blank.
- hs_start, hs_end  in  9 each  GCU hsync window bounds.
- vs_start, vs_end  in  9 each  GCU vsync window bounds.
- irq_line  in  9  line number for the raster interrupt.
- rd_stb  in  1  CPU status-read strobe; high for the whole bus cycle.
- ack_vbl  in  1  VBLANK interrupt acknowledge; level, rising edge is active.
- ack_raster  in  1  raster interrupt acknowledge; level, rising edge is active.
- status  out  16  GCU status word.
- irq_vbl  out  1  VBLANK interrupt request.
- irq_raster  out  1  raster interrupt request.
- frame_cnt  out  FRAME_W  frame counter.

## Operation
- **Sample tick.** A tick is a clk96 edge with pxl_cen=1. All raster state advances only on ticks.
- **Line latch.** vline (9 b) loads vpos on the tick where hpos==hs_start. It therefore changes at the hsync boundary, not at hpos 0.
- **Window flags.**
  - hwin = (hpos>=hs_start) && (hpos<hs_end).
  - vwin = (vpos>=vs_start) && (vpos<vs_end).
  - Comparisons are unsigned 9-bit.
  - A start value greater than or equal to its end value gives a window that is never active.
  - Both flags are registered each tick.
- **Blank flag.** vblk = registered ~lvbl.
- **Live status word.** {hwin, vwin, vblk, 4'b0, vline}.
- **status output and read freeze.**
  - status is a register that loads the live word on every tick while rd_stb=0.
  - While rd_stb=1, status holds its value. This prevents mid-read tearing.
  - On the cycle rd_stb falls, status reloads at the next tick.
- **VBLANK edge.** lvbl_d is lvbl registered on ticks. A falling edge is lvbl_d=1 and lvbl=0 on a tick.
- **VBLANK interrupt.**
  - A VBLANK edge sets pend_vbl and increments frame_cnt. frame_cnt wraps from all-ones to 0.
  - irq_vbl = pend_vbl.
  - A rising edge of ack_vbl clears pend_vbl. The edge is detected every clk96 cycle with an ack_vbl_d register, independent of pxl_cen.
  - If a set and a clear occur in the same cycle, set wins and pend_vbl stays 1.
- **Raster interrupt (RASTER_EN=1).**
  - On the tick where vpos==irq_line and hpos==hs_start, pend_raster is set.
  - It is cleared by a rising edge of ack_raster, with the same set-wins rule.
  - irq_line values above 262 never fire.
  - If irq_line changes mid-frame, the new value is used from the next tick.
- **Pending set while already pending.** No effect and no counting; only one interrupt is outstanding per source.
- **Reset mid-operation.** All registers return immediately (asynchronously) to their reset values. The edge detectors restart from lvbl_d=1, so no spurious edge is seen after reset.

## Timing
- **Reset values:** status=0, irq_vbl=0, irq_raster=0, frame_cnt=0, vline=0. Internal registers: lvbl_d=1, ack_vbl_d=0, ack_raster_d=0.
- **Status latency.** A change on hpos/vpos/lvbl appears in status 2 ticks later: 1 tick to register the flags/vline, 1 tick for the status register.
- **Interrupt latency.** irq_vbl and irq_raster assert 1 clk96 cycle after the tick on which their condition is detected.
- **Acknowledge latency.** The interrupt deasserts 1 clk96 cycle after the cycle in which ack rises.
- **Held acknowledge.** An ack held high does not block a later set; only its rising edge clears.
- **No combinational paths.** There is no combinational path from any input to any output.

## Test plan
Common setup for all scenarios: hs_start=325, hs_end=380, vs_start=232, vs_end=245, full 432x263 raster, pxl_cen every 4th clk96.

- **Line latch:** run one frame.
  - vline changes from 99 to 100 only at vpos=100, hpos=325.
  - status[8:0]=100 two ticks later.
  - status[15]=1 for hpos 325..379 and 0 at 380.
- **VBLANK interrupt:** drive lvbl low at the vpos=240 transition.
  - irq_vbl=1 one cycle after the edge tick; frame_cnt goes 0 to 1.
  - Pulse ack_vbl; irq_vbl=0 one cycle later.
  - Run 256 frames; frame_cnt wraps to 0.
- **Set/ack collision:** raise ack_vbl in the same cycle as the VBLANK edge tick -> irq_vbl stays 1.
- **Raster interrupt:**
  - irq_line=100 -> irq_raster rises after the tick at vpos=100, hpos=325, and only there.
  - irq_line=300 -> it never fires across 2 frames.
  - With RASTER_EN=0 it is always 0.
- **Read freeze:** hold rd_stb=1 across the hpos=325 boundary.
  - status is unchanged while rd_stb=1.
  - status updates at the first tick after rd_stb falls.
- **Reset mid-frame:** assert reset96=0 at vpos=150 with irq_vbl=1.
  - All outputs are 0 immediately.
  - After release, there is no irq_vbl until the next true lvbl falling edge.
